pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and forward control for a 5-stage pipe with an MDU interlock
// Optional macro HU_BRANCH_FWD_EN adds M-to-D forwarding into the branch comparator.
module pipe_hazard_ctrl #(
   parameter int REG_W   = 5,
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             BranchD,
   input  logic             MduReadD,
   input  logic             MduStartE,
   input  logic             MemToRegE,
   input  logic             RegWriteE,
   input  logic             MemToRegM,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic [REG_W-1:0] RsD,
   input  logic [REG_W-1:0] RtD,
   input  logic [REG_W-1:0] RsE,
   input  logic [REG_W-1:0] RtE,
   input  logic [REG_W-1:0] WriteRegE,
   input  logic [REG_W-1:0] WriteRegM,
   input  logic [REG_W-1:0] WriteRegW,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MduBusy,
   output logic [CNT_W-1:0] StallCnt
);

   localparam logic [7:0] MDU_LOAD = 8'(MDU_LAT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

   mdu_state_t       state_q, state_d;
   logic [7:0]       mdu_cnt_q, mdu_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       lw_stall;
   logic       branch_stall;
   logic       mdu_stall;
   logic       stall;
   logic       fwd_ad;
   logic       fwd_bd;
   logic [1:0] fwd_ae;
   logic [1:0] fwd_be;
   logic       unused_mem_to_reg_m;

   assign unused_mem_to_reg_m = MemToRegM;

   // Register 0 is hardwired, so a zero destination never produces a hit.
   function automatic logic reg_hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
      return (dst != '0) && (src == dst);
   endfunction

   always_comb begin
      fwd_ae = 2'b00;
      if (RegWriteM && reg_hit(RsE, WriteRegM)) begin
         fwd_ae = 2'b10;
      end else if (RegWriteW && reg_hit(RsE, WriteRegW)) begin
         fwd_ae = 2'b01;
      end
      fwd_be = 2'b00;
      if (RegWriteM && reg_hit(RtE, WriteRegM)) begin
         fwd_be = 2'b10;
      end else if (RegWriteW && reg_hit(RtE, WriteRegW)) begin
         fwd_be = 2'b01;
      end
   end

   always_comb begin
      lw_stall = MemToRegE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE));
`ifdef HU_BRANCH_FWD_EN
      fwd_ad = RegWriteM && !MemToRegM && reg_hit(RsD, WriteRegM);
      fwd_bd = RegWriteM && !MemToRegM && reg_hit(RtD, WriteRegM);
      // An ALU result in M is forwarded; only E producers and M loads still stall.
      branch_stall = BranchD &&
                     ((RegWriteE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE))) ||
                      (MemToRegM && (reg_hit(RsD, WriteRegM) || reg_hit(RtD, WriteRegM))));
`else
      fwd_ad = 1'b0;
      fwd_bd = 1'b0;
      branch_stall = BranchD &&
                     ((RegWriteE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE))) ||
                      (RegWriteM && (reg_hit(RsD, WriteRegM) || reg_hit(RtD, WriteRegM))));
`endif
      // A start in E makes the result unavailable this cycle as well.
      mdu_stall = MduReadD && ((state_q == BUSY) || MduStartE);
      stall     = lw_stall || branch_stall || mdu_stall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mdu_cnt_q   <= 8'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mdu_cnt_q   <= mdu_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mdu_cnt_d = mdu_cnt_q;
      case (state_q)
         IDLE: begin
            if (MduStartE) begin
               state_d   = BUSY;
               mdu_cnt_d = MDU_LOAD;
            end
         end
         BUSY: begin
            // A start while busy is ignored and leaves the countdown alone.
            if (mdu_cnt_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               mdu_cnt_d = mdu_cnt_q - 8'd1;
            end
         end
      endcase
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      MduBusy   = 1'b0;
      if (!reset) begin
         StallF    = stall;
         StallD    = stall;
         FlushE    = stall;
         ForwardAD = fwd_ad;
         ForwardBD = fwd_bd;
         ForwardAE = fwd_ae;
         ForwardBE = fwd_be;
         MduBusy   = (state_q == BUSY);
      end
      StallCnt = stall_cnt_q;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a reference model
module tb_pipe_hazard_ctrl;
   localparam int REG_W     = 5;
   localparam int LAT       = 4;
   localparam int LAT_S     = 1;
   localparam int CNT_MAX   = 65535;
   localparam int CNT_MAX_S = 3;

   logic clk = 1'b0;
   logic reset;
   logic BranchD, MduReadD, MduStartE, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW;
   logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;

   logic StallF, StallD, FlushE, ForwardAD, ForwardBD, MduBusy;
   logic [1:0] ForwardAE, ForwardBE;
   logic [15:0] StallCnt;

   logic s_StallF, s_StallD, s_FlushE, s_ForwardAD, s_ForwardBD, s_MduBusy;
   logic [1:0] s_ForwardAE, s_ForwardBE;
   logic [1:0] s_StallCnt;

   int n_checks = 0;
   int n_errors = 0;
   // Model: remaining BUSY cycles (0 = idle) and stall totals, per instance.
   int m_busy, m_cnt, m_busy_s, m_cnt_s;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_W(REG_W), .MDU_LAT(LAT), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .BranchD(BranchD), .MduReadD(MduReadD), .MduStartE(MduStartE),
      .MemToRegE(MemToRegE), .RegWriteE(RegWriteE), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
      .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MduBusy(MduBusy), .StallCnt(StallCnt)
   );

   pipe_hazard_ctrl #(.REG_W(REG_W), .MDU_LAT(LAT_S), .CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .BranchD(BranchD), .MduReadD(MduReadD), .MduStartE(MduStartE),
      .MemToRegE(MemToRegE), .RegWriteE(RegWriteE), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
      .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .StallF(s_StallF), .StallD(s_StallD),
      .FlushE(s_FlushE), .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD), .ForwardAE(s_ForwardAE),
      .ForwardBE(s_ForwardBE), .MduBusy(s_MduBusy), .StallCnt(s_StallCnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
      return (dst != 0) && (src == dst);
   endfunction

   function automatic logic exp_stall(input logic busy);
      logic lw, br, md;
      lw = MemToRegE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE));
`ifdef HU_BRANCH_FWD_EN
      br = BranchD && ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                       (MemToRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
`else
      br = BranchD && ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                       (RegWriteM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
`endif
      md = MduReadD && (busy || MduStartE);
      return lw || br || md;
   endfunction

   function automatic logic [1:0] exp_fwd_e(input logic [REG_W-1:0] src);
      if (RegWriteM && hit(src, WriteRegM)) return 2'b10;
      if (RegWriteW && hit(src, WriteRegW)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic exp_fwd_d(input logic [REG_W-1:0] src);
`ifdef HU_BRANCH_FWD_EN
      return RegWriteM && !MemToRegM && hit(src, WriteRegM);
`else
      return 1'b0 && (src != 0);
`endif
   endfunction

   task automatic clear_inputs();
      BranchD = 0; MduReadD = 0; MduStartE = 0; MemToRegE = 0; RegWriteE = 0;
      MemToRegM = 0; RegWriteM = 0; RegWriteW = 0;
      RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
   endtask

   task automatic settle();
      logic st, st_s;
      #1;
      st   = !reset && exp_stall(m_busy > 0);
      st_s = !reset && exp_stall(m_busy_s > 0);
      chk("StallF", StallF, st);
      chk("StallD", StallD, st);
      chk("FlushE", FlushE, st);
      chk("ForwardAD", ForwardAD, !reset && exp_fwd_d(RsD));
      chk("ForwardBD", ForwardBD, !reset && exp_fwd_d(RtD));
      chk("ForwardAE", ForwardAE, reset ? 2'b00 : exp_fwd_e(RsE));
      chk("ForwardBE", ForwardBE, reset ? 2'b00 : exp_fwd_e(RtE));
      chk("MduBusy", MduBusy, !reset && (m_busy > 0));
      chk("StallCnt", StallCnt, m_cnt);
      chk("s_StallF", s_StallF, st_s);
      chk("s_MduBusy", s_MduBusy, !reset && (m_busy_s > 0));
      chk("s_StallCnt", s_StallCnt, m_cnt_s);
   endtask

   task automatic advance();
      logic st, st_s;
      st   = exp_stall(m_busy > 0);
      st_s = exp_stall(m_busy_s > 0);
      if (reset) begin
         m_busy = 0; m_cnt = 0; m_busy_s = 0; m_cnt_s = 0;
      end else begin
         if (st && m_cnt < CNT_MAX) m_cnt++;
         if (st_s && m_cnt_s < CNT_MAX_S) m_cnt_s++;
         if (m_busy > 0) m_busy--; else if (MduStartE) m_busy = LAT;
         if (m_busy_s > 0) m_busy_s--; else if (MduStartE) m_busy_s = LAT_S;
      end
      @(negedge clk);
   endtask

   initial begin
      m_busy = 0; m_cnt = 0; m_busy_s = 0; m_cnt_s = 0;
      clear_inputs();
      reset = 1;
      @(negedge clk);

      // Hazards present while reset is held must not show on the outputs.
      MemToRegE = 1; WriteRegE = 9; RtD = 9; RegWriteM = 1; WriteRegM = 8; RsE = 8;
      settle();
      chk("rst_stall", StallF, 1'b0);
      chk("rst_fwd_ae", ForwardAE, 2'b00);
      chk("rst_cnt", StallCnt, 16'd0);
      advance();
      reset = 0;

      clear_inputs();
      RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; RsE = 8;
      settle();
      chk("fwd_m_prio", ForwardAE, 2'b10);
      WriteRegM = 0; RsE = 0; RtE = 8;
      settle();
      chk("fwd_r0", ForwardAE, 2'b00);
      chk("fwd_w", ForwardBE, 2'b01);
      advance();

      clear_inputs();
      MemToRegE = 1; WriteRegE = 9; RtD = 9;
      settle();
      chk("lw_stall", StallF, 1'b1);
      advance();
      clear_inputs();
      settle();
      chk("lw_stall_end", StallF, 1'b0);
      chk("lw_cnt", StallCnt, 16'd1);
      advance();

      clear_inputs();
      MduStartE = 1; MduReadD = 1;
      settle();
      chk("mdu_start_stall", StallF, 1'b1);
      chk("mdu_start_idle", MduBusy, 1'b0);
      advance();
      for (int i = 0; i < LAT; i++) begin
         MduStartE = (i == 1);
         settle();
         chk("mdu_busy", MduBusy, 1'b1);
         chk("mdu_busy_stall", StallF, 1'b1);
         advance();
      end
      MduStartE = 0;
      settle();
      chk("mdu_done", MduBusy, 1'b0);
      chk("mdu_done_stall", StallF, 1'b0);
      chk("mdu_cnt", StallCnt, 16'd6);
      advance();

      clear_inputs();
      BranchD = 1; RegWriteM = 1; MemToRegM = 0; WriteRegM = 5; RsD = 5;
      settle();
`ifdef HU_BRANCH_FWD_EN
      chk("br_fwd", ForwardAD, 1'b1);
      chk("br_nostall", StallF, 1'b0);
`else
      chk("br_stall", StallF, 1'b1);
      chk("br_nofwd", ForwardAD, 1'b0);
`endif
      advance();

      clear_inputs();
      MduStartE = 1;
      settle();
      advance();
      MduStartE = 0;
      settle();
      advance();
      reset = 1;
      settle();
      advance();
      reset = 0;
      settle();
      chk("rst_busy", MduBusy, 1'b0);
      chk("rst_cnt_clr", StallCnt, 16'd0);
      advance();

      MemToRegE = 1; WriteRegE = 9; RsD = 9;
      for (int i = 0; i < 5; i++) begin
         settle();
         advance();
      end
      clear_inputs();
      settle();
      chk("sat_small", s_StallCnt, 2'd3);
      chk("sat_main", StallCnt, 16'd5);
      advance();

      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 49) == 0);
         BranchD   = ($urandom_range(0, 3) == 0);
         MduReadD  = ($urandom_range(0, 2) == 0);
         MduStartE = ($urandom_range(0, 5) == 0);
         MemToRegE = 1'($urandom_range(0, 1));
         RegWriteE = 1'($urandom_range(0, 1));
         MemToRegM = 1'($urandom_range(0, 1));
         RegWriteM = 1'($urandom_range(0, 1));
         RegWriteW = 1'($urandom_range(0, 1));
         RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
         RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
         WriteRegE = 5'($urandom_range(0, 3));
         WriteRegM = 5'($urandom_range(0, 3));
         WriteRegW = 5'($urandom_range(0, 3));
         settle();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
